// File: rtl/morse_ram_scheduler_pkg.sv
// Shared constants and types for the morse answer-RAM scheduler.
// Symbol codes, word/address widths, round size and FSM state encoding.
package morse_ram_scheduler_pkg;

    localparam int DATA_W  = 10;
    localparam int WORDS   = 4;
    localparam int ADDR_W  = 5;
    localparam int P2_BASE = 16;
    localparam int CNT_W   = $clog2(WORDS + 1);
    localparam int IDX_W   = $clog2(WORDS);

    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b11;

    localparam logic [CNT_W-1:0]  WORDS_MAX = CNT_W'(WORDS);
    localparam logic [ADDR_W-1:0] P2_ADDR   = ADDR_W'(P2_BASE);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS - 1);

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_RD_A,
        ST_RD_B,
        ST_CMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/morse_ram_scheduler_if.sv
// Single-port answer RAM bus between the scheduler and the RAM.
// master: drives ram_address/ram_data/ram_wren, reads ram_q; slave: the RAM side.
interface morse_ram_scheduler_if;
    import morse_ram_scheduler_pkg::*;

    logic [ADDR_W-1:0] ram_address;
    word_t             ram_data;
    logic              ram_wren;
    word_t             ram_q;

    modport master (
        output ram_address,
        output ram_data,
        output ram_wren,
        input  ram_q
    );

    modport slave (
        input  ram_address,
        input  ram_data,
        input  ram_wren,
        output ram_q
    );

endinterface

// File: rtl/morse_ram_scheduler_arbiter.sv
// Per-player pending latches, round-robin write grant and address/count generation.
// In: clock, reset, collect, clear, p1/p2 strobes+words. Out: grant bundle, counts, pend_any, drop.
module morse_ram_scheduler_arbiter
    import morse_ram_scheduler_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              collect,
    input  logic              clear,
    input  logic              p1_write,
    input  word_t             p1_q,
    input  logic              p2_write,
    input  word_t             p2_q,
    output logic              gnt,
    output logic [ADDR_W-1:0] gnt_addr,
    output word_t             gnt_data,
    output logic [CNT_W-1:0]  p1_count,
    output logic [CNT_W-1:0]  p2_count,
    output logic              pend_any,
    output logic [1:0]        drop
);

    logic [1:0] pend;
    word_t      word1;
    word_t      word2;
    logic       ptr;
    logic       g1;
    logic       g2;
    logic       acc1;
    logic       acc2;

    // ptr=0 favours p1. A strobe arriving in its own grant cycle is
    // accepted only if the slot after the granted one still fits.
    always_comb begin
        g1 = collect && pend[0] && (!pend[1] || !ptr);
        g2 = collect && pend[1] && (!pend[0] || ptr);
        acc1 = collect && p1_write &&
               (g1 ? (p1_count + CNT_W'(1) < WORDS_MAX)
                   : (!pend[0] && p1_count < WORDS_MAX));
        acc2 = collect && p2_write &&
               (g2 ? (p2_count + CNT_W'(1) < WORDS_MAX)
                   : (!pend[1] && p2_count < WORDS_MAX));
        gnt      = g1 || g2;
        gnt_addr = g1 ? ADDR_W'(p1_count)
                      : P2_ADDR + ADDR_W'(p2_count);
        gnt_data = g1 ? word1 : word2;
    end

    assign pend_any = |pend;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend     <= 2'b00;
            word1    <= '0;
            word2    <= '0;
            ptr      <= 1'b0;
            p1_count <= '0;
            p2_count <= '0;
            drop     <= 2'b00;
        end else if (clear) begin
            pend     <= 2'b00;
            p1_count <= '0;
            p2_count <= '0;
            drop     <= 2'b00;
        end else begin
            if (g1) p1_count <= p1_count + CNT_W'(1);
            if (g2) p2_count <= p2_count + CNT_W'(1);
            if (acc1) begin
                pend[0] <= 1'b1;
                word1   <= p1_q;
            end else if (g1) begin
                pend[0] <= 1'b0;
            end
            if (acc2) begin
                pend[1] <= 1'b1;
                word2   <= p2_q;
            end else if (g2) begin
                pend[1] <= 1'b0;
            end
            if (collect && pend[0] && pend[1]) ptr <= !ptr;
            drop <= drop | {p2_write && !acc2, p1_write && !acc1};
        end
    end

endmodule

// File: rtl/morse_ram_scheduler.sv
// Shares the answer RAM between two morse players and compares their words per round.
// In: clock, reset, p1/p2 strobes+words, new_round, ram.ram_q. Out: ram bus, counts, busy, done, match_count, all_match, drop.
module morse_ram_scheduler
    import morse_ram_scheduler_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 p1_write,
    input  word_t                p1_q,
    input  logic                 p2_write,
    input  word_t                p2_q,
    input  logic                 new_round,
    morse_ram_scheduler_if.master ram,
    output logic [CNT_W-1:0]     p1_count,
    output logic [CNT_W-1:0]     p2_count,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     match_count,
    output logic                 all_match,
    output logic [1:0]           drop
);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  idx;
    word_t             word_a;
    logic [ADDR_W-1:0] addr_q;
    word_t             data_q;
    logic              wren_q;
    logic              gnt;
    logic [ADDR_W-1:0] gnt_addr;
    word_t             gnt_data;
    logic              pend_any;
    logic              collect;
    logic              clear;
    logic              full;
    logic              last;

    assign collect = (state == ST_COLLECT);
    assign clear   = (state == ST_DONE) && new_round;
    assign full    = (p1_count == WORDS_MAX) && (p2_count == WORDS_MAX);
    assign last    = (idx == IDX_LAST);

    morse_ram_scheduler_arbiter u_arbiter (
        .clock    (clock),
        .reset    (reset),
        .collect  (collect),
        .clear    (clear),
        .p1_write (p1_write),
        .p1_q     (p1_q),
        .p2_write (p2_write),
        .p2_q     (p2_q),
        .gnt      (gnt),
        .gnt_addr (gnt_addr),
        .gnt_data (gnt_data),
        .p1_count (p1_count),
        .p2_count (p2_count),
        .pend_any (pend_any),
        .drop     (drop)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_COLLECT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_COLLECT: if (full && !pend_any) next_state = ST_RD_A;
            ST_RD_A:    next_state = ST_RD_B;
            ST_RD_B:    next_state = ST_CMP;
            ST_CMP:     next_state = last ? ST_DONE : ST_RD_A;
            ST_DONE:    if (new_round) next_state = ST_COLLECT;
            default:    next_state = ST_COLLECT;
        endcase
    end

    always_comb begin
        busy      = (state == ST_RD_A) || (state == ST_RD_B) ||
                    (state == ST_CMP);
        all_match = (match_count == WORDS_MAX);
    end

    // The RAM address register is loaded one state ahead, so the
    // address is on the bus during the state that names it and the
    // read data arrives in the following state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            idx         <= '0;
            word_a      <= '0;
            match_count <= '0;
            done        <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                ST_COLLECT: begin
                    if (gnt) begin
                        wren_q <= 1'b1;
                        addr_q <= gnt_addr;
                        data_q <= gnt_data;
                    end
                    if (next_state == ST_RD_A) begin
                        idx         <= '0;
                        match_count <= '0;
                        addr_q      <= '0;
                    end
                end
                ST_RD_A: addr_q <= P2_ADDR + ADDR_W'(idx);
                ST_RD_B: word_a <= ram.ram_q;
                ST_CMP: begin
                    if (ram.ram_q == word_a && match_count != WORDS_MAX)
                        match_count <= match_count + CNT_W'(1);
                    if (last) begin
                        done <= 1'b1;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                        addr_q <= ADDR_W'(idx + IDX_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram.ram_address = addr_q;
    assign ram.ram_data    = data_q;
    assign ram.ram_wren    = wren_q;

endmodule
